// File: rtl/sprite_fetch_pkg.sv
// Shared types and defaults for the sprite fetch master.
// SPRITE_FETCH_TRANSPARENCY_EN adds a transparency flag to each FIFO entry.
package sprite_fetch_pkg;

   localparam int ADDR_W_DEF      = 16;
   localparam int DATA_W_DEF      = 8;
   localparam int DIM_W_DEF       = 8;
   localparam int EXT_W           = ADDR_W_DEF + DIM_W_DEF;
   localparam int DEPTH_WORDS_DEF = 60000;
   localparam logic [DATA_W_DEF-1:0] TRANSP_KEY_DEF = 8'hE3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  eol;
      logic                  eof;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
      logic                  transparent;
`endif
   } pix_entry_t;

   // Widened so that no legal field combination can wrap before the range check.
   function automatic logic [EXT_W-1:0] sprite_end(
      input logic [ADDR_W_DEF-1:0] base,
      input logic [DIM_W_DEF-1:0]  width,
      input logic [DIM_W_DEF-1:0]  height,
      input logic [ADDR_W_DEF-1:0] stride
   );
      return EXT_W'(base)
           + EXT_W'(height - DIM_W_DEF'(1)) * EXT_W'(stride)
           + EXT_W'(width - DIM_W_DEF'(1));
   endfunction

endpackage

// File: rtl/sprite_fetch_master_if.sv
// Command, sprite-memory and pixel-stream signals of the sprite fetch master.
// SPRITE_FETCH_TRANSPARENCY_EN adds pix_transparent.
interface sprite_fetch_master_if
   import sprite_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base;
   logic [DIM_W-1:0]  cmd_width;
   logic [DIM_W-1:0]  cmd_height;
   logic [ADDR_W-1:0] cmd_stride;

   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] pix_data;
   logic              pix_eol;
   logic              pix_eof;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
   logic              pix_transparent;
`endif

   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride,
      output cmd_ready,
      output mem_address, mem_chipselect, mem_write, mem_clken,
      input  mem_readdata,
      output pix_valid, pix_data, pix_eol, pix_eof,
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
      output pix_transparent,
`endif
      input  pix_ready,
      output busy, done, err
   );

   modport slave (
      output cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride,
      input  cmd_ready,
      input  mem_address, mem_chipselect, mem_write, mem_clken,
      output mem_readdata,
      input  pix_valid, pix_data, pix_eol, pix_eof,
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
      input  pix_transparent,
`endif
      output pix_ready,
      input  busy, done, err
   );

endinterface

// File: rtl/sprite_fetch_fifo.sv
// Generic synchronous FIFO with occupancy count; zero-latency head, one-cycle write-to-valid.
// No overflow/underflow guard: the caller's credit scheme keeps it in range.
module sprite_fetch_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en,
   input  T                       wr_data,
   input  logic                   rd_en,
   output T                       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);

endmodule

// File: rtl/sprite_fetch_master.sv
// Avalon-MM sprite read master: row-major pixel stream, first pixel 3 cycles after command.
// Reads are credit-limited by the output FIFO; SPRITE_FETCH_TRANSPARENCY_EN adds pix_transparent.
module sprite_fetch_master
   import sprite_fetch_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DIM_W       = DIM_W_DEF,
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int FIFO_DEPTH  = 4
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
   ,
   parameter logic [DATA_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF
`endif
) (
   input logic                  clk,
   input logic                  reset_n,
   sprite_fetch_master_if.master bus
);
   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] FETCH = ST_FETCH;
   localparam logic [1:0] DRAIN = ST_DRAIN;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]              state;
   logic [DIM_W-1:0]        col, row, width_r, height_r;
   logic [ADDR_W-1:0]       row_addr, stride_r;
   logic                    inflight, tag_eol, tag_eof;
   logic                    done_q, err_q;

   logic                    accept, zero_size, out_of_range;
   logic                    credit_ok, issue, last_col, last_row, drain_done, pop;
   logic [ADDR_W+DIM_W-1:0] end_addr;

   pix_entry_t              wr_entry, head;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;

   assign accept       = bus.cmd_valid && (state == IDLE);
   assign zero_size    = (bus.cmd_width == '0) || (bus.cmd_height == '0);
   assign end_addr     = sprite_end(bus.cmd_base, bus.cmd_width, bus.cmd_height, bus.cmd_stride);
   assign out_of_range = end_addr >= (ADDR_W+DIM_W)'(DEPTH_WORDS);

   // A read in flight already owns a FIFO slot even though it is not yet counted.
   assign credit_ok  = ({1'b0, fifo_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH);
   assign issue      = (state == FETCH) && credit_ok;
   assign last_col   = (col == width_r - DIM_W'(1));
   assign last_row   = (row == height_r - DIM_W'(1));
   assign drain_done = (state == DRAIN) && !inflight && fifo_empty;
   assign pop        = !fifo_empty && bus.pix_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         width_r  <= '0;
         height_r <= '0;
         row_addr <= '0;
         stride_r <= '0;
         inflight <= 1'b0;
         tag_eol  <= 1'b0;
         tag_eof  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         inflight <= issue;
         if (issue) begin
            tag_eol <= last_col;
            tag_eof <= last_col && last_row;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (zero_size) begin
                     done_q <= 1'b1;
                  end else if (out_of_range) begin
                     err_q <= 1'b1;
                  end else begin
                     width_r  <= bus.cmd_width;
                     height_r <= bus.cmd_height;
                     stride_r <= bus.cmd_stride;
                     row_addr <= bus.cmd_base;
                     col      <= '0;
                     row      <= '0;
                     state    <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (issue) begin
                  if (last_col) begin
                     col      <= '0;
                     row      <= row + DIM_W'(1);
                     row_addr <= row_addr + stride_r;
                     if (last_row) state <= DRAIN;
                  end else begin
                     col <= col + DIM_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (drain_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = bus.mem_readdata;
      wr_entry.eol  = tag_eol;
      wr_entry.eof  = tag_eof;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
      wr_entry.transparent = (bus.mem_readdata == TRANSP_KEY);
`endif
   end

   sprite_fetch_fifo #(
      .T     (pix_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (inflight),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   assign bus.cmd_ready      = (state == IDLE);
   assign bus.mem_chipselect = issue;
   assign bus.mem_address    = issue ? (row_addr + ADDR_W'(col)) : '0;
   assign bus.mem_write      = 1'b0;
   assign bus.mem_clken      = 1'b1;
   assign bus.pix_valid      = !fifo_empty;
   assign bus.pix_data       = DATA_W'(head.data);
   assign bus.pix_eol        = head.eol;
   assign bus.pix_eof        = head.eof;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
   assign bus.pix_transparent = head.transparent;
`endif
   assign bus.busy           = (state != IDLE);
   assign bus.done           = done_q || drain_done;
   assign bus.err            = err_q;

endmodule

// File: doc/sprite_fetch_master.md
# sprite_fetch_master

Avalon-MM read master that fetches a rectangular sprite from the 8-bit, 60000-word on-chip sprite memory and streams its pixels row-major to the video pipeline over a valid/ready interface. It sits between the sprite command source (NIOS register block or scanline scheduler) and the sprite memory's s1 port. It issues one read per cycle and absorbs the memory's one-cycle read latency. Downstream backpressure is handled with a credit-limited output FIFO.

## Interface
- ADDR_W, 16, memory word address width
- DATA_W, 8, pixel/memory data width
- DEPTH_WORDS, 60000, number of valid memory words; reads at or beyond this address are illegal
- DIM_W, 8, width of the sprite width/height fields
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (IDLE)
- cmd_base  in  ADDR_W  address of top-left pixel
- cmd_width  in  DIM_W  pixels per row
- cmd_height  in  DIM_W  rows
- cmd_stride  in  ADDR_W  address step between rows
- mem_address  out  ADDR_W  read address to sprite memory
- mem_chipselect  out  1  read strobe; 1 only in cycles that issue a read
- mem_write  out  1  constant 0
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  memory data, valid one cycle after the address
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  DATA_W  pixel value
- pix_eol  out  1  pixel is last in its row
- pix_eof  out  1  pixel is last of sprite
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when a command completes (including zero-size)
- err  out  1  one-cycle pulse when a command is rejected for range

## Operation
- FSM states: IDLE, FETCH, DRAIN. Reset → IDLE.
- IDLE: cmd_ready=1. On cmd_valid, the command is accepted.
  - If width==0 or height==0: done pulses next cycle, no reads, stay IDLE.
  - Else compute end = base + (height-1)*stride + (width-1) in ADDR_W+DIM_W bits (no wrap). If end ≥ DEPTH_WORDS: err pulses next cycle, no reads, stay IDLE. Else → FETCH.
- FETCH: col counter 0..width-1, row counter 0..height-1, row_addr register (starts at base, += stride per row). mem_address = row_addr + col.
  - A read issues when credits allow: fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1.
  - Each issued read tags eol/eof, delayed one cycle alongside the data.
  - After the final read issues → DRAIN.
- DRAIN: wait until inflight==0 and FIFO is empty → IDLE, done pulses.
- Read data is written into the FIFO on the cycle after issue, together with its tags. Credits guarantee the FIFO never overflows.
- Pixel output is the FIFO head. A transfer occurs when pix_valid & pix_ready.
- Reset mid-operation: all state, counters and FIFO clear asynchronously. No partial stream resumes.

## Timing
- Reset values: cmd_ready=1, mem_chipselect=0, mem_address=0, mem_write=0, mem_clken=1, pix_valid=0, pix_data=0, pix_eol=0, pix_eof=0, busy=0, done=0, err=0.
- Command accepted at edge E0.
- First read is issued in cycle E0+1.
- First pixel is written to the FIFO at E0+2; pix_valid=1 in cycle E0+2 → 3-cycle latency.
- With pix_ready held at 1: one pixel per cycle sustained, no bubbles between rows.
- With pix_ready=0: reads stop once FIFO_DEPTH credits are used. No data is lost. Reads resume the cycle after the first transfer frees a credit.
- done is asserted in the cycle after the eof pixel transfers.
- The next command is accepted no earlier than that cycle.

## Configuration
- SPRITE_FETCH_TRANSPARENCY_EN defined:
  - adds parameter TRANSP_KEY (default 8'hE3) and output pix_transparent (1 bit);
  - pix_transparent=1 when pix_data==TRANSP_KEY; it is registered in the FIFO with the data and resets to 0.
- Undefined: the port and comparator are absent; all other behaviour is identical.

## Structure
- Package sprite_fetch_pkg holds:
  - state enum (IDLE/FETCH/DRAIN);
  - DEPTH_WORDS default;
  - TRANSP_KEY default;
  - the FIFO entry struct {data, eol, eof[, transparent]}.
- Sub-module sprite_fetch_fifo: synchronous FIFO with count output, asynchronous active-low reset, and no overflow/underflow protection required (credits guarantee it).

## Test plan
- base=0x0100, width=4, height=2, stride=16, pix_ready=1 → reads 0x100–0x103, 0x110–0x113 in consecutive cycles; 8 pixels; eol on the 4th and 8th; eof on the 8th; first pix_valid 3 cycles after accept; done one cycle after the last transfer.
- Same command with pix_ready toggling 1/0 every cycle → identical pixel sequence; mem_chipselect never leads to more than 4 outstanding entries.
- width=0, height=5 → no mem_chipselect; done pulse one cycle after accept; err=0.
- base=59990, width=8, height=2, stride=8 → end=60005 ≥ 60000 → err pulse; no reads; cmd_ready stays 1. Repeat with height=1 (end 59997) → accepted, 8 pixels.
- reset_n asserted mid-FETCH with 2 pixels in the FIFO → outputs at reset values immediately; after release, a new 1×1 command at 0x0000 returns memory[0] with eol=eof=1.
- With SPRITE_FETCH_TRANSPARENCY_EN: memory words {0xE3, 0x12} fetched as 2×1 → pix_transparent 1 then 0.
